bp_fe_icache_req_arbiter: RTL and testbench
===========================================

// Module: bp_fe_icache_req_arbiter
// PURPOSE
//  Shares one bp_fe_icache port between num_req_p fetch requesters (e.g. demand fetch, prefetch, trace port).
//  Round-robin grant, pipelined issue, stage tracking, and per-requester output credits.
//  Every instruction returned to a requester therefore has a guaranteed buffer slot.
//  Sits between the requesters and the icache wrapper.
// PARAMETERS
//  num_req_p      2   number of requesters (>=2)
//  vaddr_width_p  39  virtual address width
//  ptag_width_p   28  physical tag width
//  instr_width_p  32  returned instruction width
//  credits_p      16  response buffer slots per requester
// PORTS
//  clk_i          in   1                        clock
//  reset_i        in   1                        reset, asynchronous, active-low
//  req_v_i        in   num_req_p                request valid per requester
//  req_vaddr_i    in   num_req_p*vaddr_width_p  packed vaddr, requester i at slice i
//  req_ptag_i     in   num_req_p*ptag_width_p   packed ptag
//  req_uncached_i in   num_req_p                uncached fetch
//  req_yumi_o     in→out num_req_p              request retired (hit returned)
//  vaddr_o        out  vaddr_width_p            to icache
//  vaddr_v_o      out  1                        to icache
//  vaddr_ready_i  in   1                        icache can accept a vaddr
//  ptag_o         out  ptag_width_p             ptag of TL-stage entry
//  ptag_v_o       out  1                        TL-stage entry valid
//  uncached_o     out  1                        uncached bit of TL-stage entry
//  poison_tl_o    out  1                        kill the TL-stage access
//  data_i         in   instr_width_p            icache fetch data
//  data_v_i       in   1                        hit data valid (TV stage)
//  resp_v_o       out  num_req_p                one-hot response valid
//  resp_data_o    out  instr_width_p            response data, shared by all requesters
//  resp_credit_i  in   num_req_p                requester freed one buffer slot
//  busy_o         out  1                        TL or TV entry in flight
// BEHAVIOUR
//  Reset (async, reset_i==0):
//   - all outputs 0; TL/TV entries invalid; rr pointer 0; every credit counter = credits_p.
//  Eligibility: req_v_i[i] & credit[i]!=0 & requester i not in TL or TV.
//   - Consequence: at most one request per requester is in flight.
//  Issue (cycle N):
//   - vaddr_v_o=1 with the rr winner's vaddr when any requester is eligible; grant fires on vaddr_v_o & vaddr_ready_i.
//   - vaddr_v_o is combinational from eligibility; the winner is not registered until the grant fires.
//   - On grant: credit[w]-=1; rr pointer = w+1 (mod num_req_p); entry {id,ptag,uncached} loaded into TL.
//  TL (N+1):
//   - ptag_v_o=1, ptag_o/uncached_o from the TL entry; entry advances to TV unconditionally.
//  TV (N+2), hit (data_v_i=1):
//   - resp_v_o[id]=1 and resp_data_o=data_i, same cycle (combinational); req_yumi_o[id]=1; entry retired.
//  TV, miss (data_v_i=0):
//   - TV entry dropped, credit[id]+=1, no yumi; requester keeps req_v_i and re-arbitrates.
//   - If TL is valid in the same cycle: poison_tl_o=1, TL entry dropped (does not advance), credit[tl.id]+=1.
//  Credit counters:
//   - width $clog2(credits_p+1); per cycle delta = -grant + drop + resp_credit_i, net range -1..+2.
//   - Grant and drop never hit the same requester in one cycle.
//   - Assert counter <= credits_p; a credit return at credits_p is a protocol error: saturate and flag the assertion.
//  Miss/fill: icache holds vaddr_ready_i=0 during fill; no issue occurs and the pipeline drains.
//  Back-to-back: different requesters issue every cycle; TL and TV both valid is the steady state.
//  Protocol errors:
//   - data_v_i with TV invalid: ignored, assertion fires.
//   - req_v_i dropped while in flight: entry still completes; resp still delivered.
//  Requester inputs are sampled only at grant; later changes to vaddr/ptag do not affect the in-flight entry.
//  Mid-operation reset: pipeline cleared immediately; no resp or yumi for in-flight entries; credits restored.
// STRUCTURE
//  bp_fe_pkg:
//   - typedef bp_fe_icache_arb_entry_s {id, ptag, uncached, v}.
//   - macro `declare_bp_fe_icache_arb_entry_s(num_req_p, ptag_width_p).
//  Arbitration: bsg_arb_round_robin (existing).
//  Sub-module bp_fe_icache_arb_credit_counter:
//   - one per requester (generate loop); up/down counter with sat-check assertion.
//  Top level: eligibility mask, TL/TV registers, miss/poison logic, resp demux.
// TESTING (bench: trace replay per requester, random credit return, bp_nonsynth_mem)
//  1. Reset with req_v_i=2'b11 held -> no vaddr_v_o before release; first grant req0, then req1 next cycle.
//  2. Both hit-stream 8 fetches -> grants alternate 0,1,0,1; resp_v_o N+2 after each grant; 16 yumis total.
//  3. Req0 miss at 0x8000_0040 while req1 in TL -> poison_tl_o=1 that cycle; both re-issue after fill.
//     -> req0 data then req1 data; credits back to 15 each while awaiting resp_credit_i.
//  4. credits_p=4, withhold resp_credit_i on req1 -> req1 stalls after 4 resps; req0 streams.
//     -> single resp_credit_i pulse lets exactly one more req1 grant.
//  5. vaddr_ready_i=0 for 20 cycles with TL+TV valid -> TV hit delivered, then no issue until ready=1.
//  6. Assert reset_i=0 mid-stream (TL,TV valid) -> all outputs 0 same cycle; credits=credits_p after release.

Source files
------------

// File: rtl/bp_fe_icache_req_arbiter_pkg.sv
// rtl/bp_fe_icache_req_arbiter_pkg.sv - shared entry macro and round-robin helper for the icache request arbiter
`ifndef BP_FE_ICACHE_REQ_ARBITER_PKG_SV
`define BP_FE_ICACHE_REQ_ARBITER_PKG_SV

`define DECLARE_BP_FE_ICACHE_ARB_ENTRY_S(num_req_mp, ptag_width_mp) \
  typedef struct packed {                                          \
    logic [$clog2(num_req_mp)-1:0] id;                             \
    logic [ptag_width_mp-1:0]      ptag;                           \
    logic                          uncached;                       \
    logic                          v;                              \
  } bp_fe_icache_arb_entry_s;

package bp_fe_icache_req_arbiter_pkg;

  // idx is always below 2*n, so one conditional subtract is a full modulo
  function automatic int unsigned rr_wrap(input int unsigned idx, input int unsigned n);
    return (idx >= n) ? (idx - n) : idx;
  endfunction

endpackage

`endif

// File: rtl/bp_fe_icache_req_arbiter_if.sv
// rtl/bp_fe_icache_req_arbiter_if.sv - arbiter <-> icache wrapper bus (issue, TL, TV)
interface bp_fe_icache_req_arbiter_if
  import bp_fe_icache_req_arbiter_pkg::*;
  #(parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned ptag_width_p  = 28,
    parameter int unsigned instr_width_p = 32);

  logic [vaddr_width_p-1:0] vaddr;
  logic                     vaddr_v;
  logic                     vaddr_ready;
  logic [ptag_width_p-1:0]  ptag;
  logic                     ptag_v;
  logic                     uncached;
  logic                     poison_tl;
  logic [instr_width_p-1:0] data;
  logic                     data_v;

  modport master (
    output vaddr, vaddr_v, ptag, ptag_v, uncached, poison_tl,
    input  vaddr_ready, data, data_v
  );

  modport slave (
    input  vaddr, vaddr_v, ptag, ptag_v, uncached, poison_tl,
    output vaddr_ready, data, data_v
  );

endinterface

// File: rtl/bp_fe_icache_req_arbiter_credit_counter.sv
// rtl/bp_fe_icache_req_arbiter_credit_counter.sv - per-requester response-buffer credit counter
module bp_fe_icache_req_arbiter_credit_counter
  import bp_fe_icache_req_arbiter_pkg::*;
  #(parameter int unsigned credits_p = 16)
  (input  logic clk_i,
   input  logic reset_i,
   input  logic dec_i,
   input  logic drop_i,
   input  logic credit_i,
   output logic avail_o);

  localparam int unsigned cnt_width_lp = $clog2(credits_p + 1);
  localparam int unsigned sum_width_lp = cnt_width_lp + 2;

  logic [cnt_width_lp-1:0] count_q, count_d;
  logic [sum_width_lp-1:0] sum;
  logic                    overflow;

  // grant only fires with a nonzero count, so the sum cannot underflow
  always_comb begin
    sum      = sum_width_lp'(count_q) + sum_width_lp'(drop_i)
             + sum_width_lp'(credit_i) - sum_width_lp'(dec_i);
    overflow = (sum > sum_width_lp'(credits_p));
    count_d  = overflow ? cnt_width_lp'(credits_p) : sum[cnt_width_lp-1:0];
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) count_q <= cnt_width_lp'(credits_p);
    else          count_q <= count_d;
  end

  assign avail_o = (count_q != '0);

  always @(posedge clk_i) begin
    if (reset_i) begin
      assert (!overflow) else $error("credit return while counter full");
      assert (count_q <= cnt_width_lp'(credits_p)) else $error("credit counter above limit");
    end
  end

endmodule

// File: rtl/bp_fe_icache_req_arbiter.sv
// rtl/bp_fe_icache_req_arbiter.sv - round-robin, credit-gated sharing of one icache port
module bp_fe_icache_req_arbiter
  import bp_fe_icache_req_arbiter_pkg::*;
  #(parameter int unsigned num_req_p     = 2,
    parameter int unsigned vaddr_width_p = 39,
    parameter int unsigned ptag_width_p  = 28,
    parameter int unsigned instr_width_p = 32,
    parameter int unsigned credits_p     = 16)
  (input  logic                              clk_i,
   input  logic                              reset_i,
   input  logic [num_req_p-1:0]              req_v_i,
   input  logic [num_req_p*vaddr_width_p-1:0] req_vaddr_i,
   input  logic [num_req_p*ptag_width_p-1:0] req_ptag_i,
   input  logic [num_req_p-1:0]              req_uncached_i,
   output logic [num_req_p-1:0]              req_yumi_o,
   bp_fe_icache_req_arbiter_if.master        icache,
   output logic [num_req_p-1:0]              resp_v_o,
   output logic [instr_width_p-1:0]          resp_data_o,
   input  logic [num_req_p-1:0]              resp_credit_i,
   output logic                              busy_o);

  localparam int unsigned id_width_lp = $clog2(num_req_p);

  `DECLARE_BP_FE_ICACHE_ARB_ENTRY_S(num_req_p, ptag_width_p)

  bp_fe_icache_arb_entry_s tl_q, tl_d, tv_q, tv_d;
  logic [id_width_lp-1:0]  rr_q, rr_d, win;

  logic [vaddr_width_p-1:0] vaddr_a [num_req_p];
  logic [ptag_width_p-1:0]  ptag_a  [num_req_p];
  logic [num_req_p-1:0]     avail, in_flight, elig, drop;
  logic                     vaddr_v, grant, hit, miss, poison, found;
  int unsigned              idx;

  for (genvar i = 0; i < num_req_p; i++) begin : g_req
    assign vaddr_a[i]   = req_vaddr_i[i*vaddr_width_p +: vaddr_width_p];
    assign ptag_a[i]    = req_ptag_i[i*ptag_width_p +: ptag_width_p];
    assign in_flight[i] = (tl_q.v && (tl_q.id == id_width_lp'(i)))
                       || (tv_q.v && (tv_q.id == id_width_lp'(i)));
    assign drop[i]      = (miss   && (tv_q.id == id_width_lp'(i)))
                       || (poison && (tl_q.id == id_width_lp'(i)));

    bp_fe_icache_req_arbiter_credit_counter #(.credits_p(credits_p)) credit_counter (
      .clk_i    (clk_i),
      .reset_i  (reset_i),
      .dec_i    (grant && (win == id_width_lp'(i))),
      .drop_i   (drop[i]),
      .credit_i (resp_credit_i[i]),
      .avail_o  (avail[i])
    );
  end

  assign elig = req_v_i & avail & ~in_flight;

  always_comb begin
    win   = rr_q;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < num_req_p; k++) begin
      idx = rr_wrap(32'(rr_q) + k, num_req_p);
      if (!found && elig[idx[id_width_lp-1:0]]) begin
        found = 1'b1;
        win   = idx[id_width_lp-1:0];
      end
    end
  end

  // gated by reset_i so the port reads idle the moment reset asserts
  assign vaddr_v = reset_i && (|elig);
  assign grant   = vaddr_v && icache.vaddr_ready;
  assign hit     = tv_q.v && icache.data_v;
  assign miss    = tv_q.v && !icache.data_v;
  assign poison  = miss && tl_q.v;

  always_comb begin
    tl_d = '0;
    if (grant) begin
      tl_d.v        = 1'b1;
      tl_d.id       = win;
      tl_d.ptag     = ptag_a[win];
      tl_d.uncached = req_uncached_i[win];
    end
    tv_d   = tl_q;
    tv_d.v = tl_q.v && !miss;
    rr_d   = grant ? id_width_lp'(rr_wrap(32'(win) + 32'd1, num_req_p)) : rr_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      tl_q <= '0;
      tv_q <= '0;
      rr_q <= '0;
    end else begin
      tl_q <= tl_d;
      tv_q <= tv_d;
      rr_q <= rr_d;
    end
  end

  assign icache.vaddr_v   = vaddr_v;
  assign icache.vaddr     = vaddr_v ? vaddr_a[win] : '0;
  assign icache.ptag_v    = tl_q.v;
  assign icache.ptag      = tl_q.ptag;
  assign icache.uncached  = tl_q.uncached;
  assign icache.poison_tl = poison;

  assign resp_v_o    = hit ? (num_req_p'(1) << tv_q.id) : '0;
  assign resp_data_o = hit ? icache.data : '0;
  assign req_yumi_o  = resp_v_o;
  assign busy_o      = tl_q.v || tv_q.v;

  always @(posedge clk_i) begin
    if (reset_i) assert (!(icache.data_v && !tv_q.v)) else $error("data_v_i with no TV entry");
  end

endmodule

// File: tb/tb_bp_fe_icache_req_arbiter.sv
// tb/tb_bp_fe_icache_req_arbiter.sv - scoreboard bench for the icache request arbiter
module tb_bp_fe_icache_req_arbiter;

  localparam int N    = 2;
  localparam int VW   = 39;
  localparam int PW   = 28;
  localparam int IW   = 32;
  localparam int CRED = 4;
  localparam int FILL = 4;

  typedef struct { int id; logic [IW-1:0] data; } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  logic [N-1:0]    req_v, req_unc, yumi, resp_v, resp_credit;
  logic [N*VW-1:0] req_vaddr_p;
  logic [N*PW-1:0] req_ptag_p;
  logic [IW-1:0]   resp_data;
  logic            busy;
  logic [VW-1:0]   va  [N];
  logic [PW-1:0]   pt  [N];
  logic            unc [N];

  bp_fe_icache_req_arbiter_if #(.vaddr_width_p(VW), .ptag_width_p(PW), .instr_width_p(IW)) ic ();

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign req_vaddr_p[g*VW +: VW] = va[g];
    assign req_ptag_p[g*PW +: PW]  = pt[g];
    assign req_unc[g]              = unc[g];
  end

  bp_fe_icache_req_arbiter #(.num_req_p(N), .vaddr_width_p(VW), .ptag_width_p(PW),
                             .instr_width_p(IW), .credits_p(CRED)) dut (
    .clk_i(clk), .reset_i(reset_n), .req_v_i(req_v), .req_vaddr_i(req_vaddr_p),
    .req_ptag_i(req_ptag_p), .req_uncached_i(req_unc), .req_yumi_o(yumi), .icache(ic),
    .resp_v_o(resp_v), .resp_data_o(resp_data), .resp_credit_i(resp_credit), .busy_o(busy));

  int n_assert = 0;
  int n_fail   = 0;

  // bench-side state: requester traces, icache pipeline view, credits, scoreboard
  int            rem [N], cred [N], owed [N], ycnt [N], gcnt [N];
  logic          hold [N], pulse [N];
  logic          rand_credit, ready_en, miss_armed;
  logic [VW-1:0] miss_addr;
  int            fill_cnt, rr, poison_cnt, miss_ylog;
  logic          m_tl_v, m_tv_v, m_tl_unc;
  int            m_tl_id, m_tv_id;
  logic [VW-1:0] m_tl_va, m_tv_va;
  logic [PW-1:0] m_tl_pt;
  exp_t          sb [$];
  int            glog [$];
  int            ylog [$];

  function automatic logic [IW-1:0] mem(input logic [VW-1:0] a);
    return a[31:0] ^ 32'h3C5A_9617 ^ {a[38:32], 25'h0};
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    m_tl_v = 0; m_tv_v = 0; rr = 0; fill_cnt = 0; miss_armed = 0;
    sb.delete();
    for (int i = 0; i < N; i++) begin cred[i] = CRED; owed[i] = 0; pulse[i] = 0; end
  endtask

  task automatic tick();
    logic miss, hit, exp_v, gnt;
    logic [N-1:0] elig, rc, exp_resp, adv;
    int w;
    exp_t e;
    for (int i = 0; i < N; i++) req_v[i] = (rem[i] > 0);
    ic.vaddr_ready = ready_en && (fill_cnt == 0);
    if (fill_cnt > 0) fill_cnt--;
    miss = m_tv_v && miss_armed && (m_tv_va == miss_addr);
    if (miss) miss_armed = 0;
    hit = m_tv_v && !miss;
    ic.data_v = hit;
    ic.data   = hit ? mem(m_tv_va) : IW'($urandom);
    for (int i = 0; i < N; i++) begin
      rc[i] = (owed[i] > 0) && ((!hold[i] && (!rand_credit || $urandom_range(0, 1) == 1)) || pulse[i]);
      if (rc[i]) pulse[i] = 0;
    end
    resp_credit = rc;
    #1;
    exp_resp = '0;
    if (hit) begin
      chk("sb_nonempty", 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        exp_resp[e.id] = 1'b1;
        chk("resp_data", resp_data, e.data);
        ycnt[e.id]++;
        ylog.push_back(e.id);
      end
    end
    chk("resp_v", resp_v, exp_resp);
    chk("yumi", yumi, exp_resp);
    chk("poison_tl", ic.poison_tl, miss && m_tl_v);
    chk("ptag_v", ic.ptag_v, m_tl_v);
    if (m_tl_v) begin
      chk("ptag", ic.ptag, m_tl_pt);
      chk("uncached", ic.uncached, m_tl_unc);
    end
    chk("busy", busy, m_tl_v || m_tv_v);
    for (int i = 0; i < N; i++)
      elig[i] = req_v[i] && (cred[i] != 0) && !(m_tl_v && m_tl_id == i) && !(m_tv_v && m_tv_id == i);
    exp_v = |elig;
    w = 0;
    for (int k = N - 1; k >= 0; k--) if (elig[(rr + k) % N]) w = (rr + k) % N;
    chk("vaddr_v", ic.vaddr_v, exp_v);
    if (exp_v) chk("vaddr", ic.vaddr, va[w]);
    gnt = exp_v && ic.vaddr_ready;
    adv = '0;
    if (miss) begin
      cred[m_tv_id]++;
      void'(sb.pop_front());
      fill_cnt = FILL;
      miss_ylog = ylog.size();
      if (m_tl_v) begin poison_cnt++; cred[m_tl_id]++; void'(sb.pop_front()); end
    end
    if (hit) begin owed[m_tv_id]++; adv[m_tv_id] = 1'b1; end
    for (int i = 0; i < N; i++) if (rc[i]) begin owed[i]--; cred[i]++; end
    m_tv_v = m_tl_v && !miss; m_tv_id = m_tl_id; m_tv_va = m_tl_va;
    m_tl_v = gnt;
    if (gnt) begin
      m_tl_id = w; m_tl_va = va[w]; m_tl_pt = pt[w]; m_tl_unc = unc[w];
      cred[w]--; rr = (w + 1) % N; gcnt[w]++; glog.push_back(w);
      sb.push_back('{w, mem(va[w])});
    end
    @(posedge clk); #1;
    // the in-flight entry must not follow later requester input changes
    if (gnt) begin pt[w] = PW'($urandom); unc[w] = 1'($urandom_range(0, 1)); end
    for (int i = 0; i < N; i++) if (adv[i]) begin rem[i]--; va[i] = va[i] + 39'd4; end
  endtask

  task automatic run_idle(input int budget);
    int n = 0;
    while ((rem[0] > 0 || rem[1] > 0 || m_tl_v || m_tv_v || owed[0] > 0 || owed[1] > 0) && n < budget) begin
      tick(); n++;
    end
    chk("idle_timeout", 64'(n >= budget), 64'd0);
    tick(); tick();
  endtask

  task automatic wait_full(input int budget);
    int n = 0;
    while (!(m_tl_v && m_tv_v) && n < budget) begin tick(); n++; end
    chk("full_timeout", 64'(n >= budget), 64'd0);
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_vaddr_v"}, ic.vaddr_v, 0);
    chk({tag, "_vaddr"}, ic.vaddr, 0);
    chk({tag, "_ptag_v"}, ic.ptag_v, 0);
    chk({tag, "_ptag"}, ic.ptag, 0);
    chk({tag, "_poison"}, ic.poison_tl, 0);
    chk({tag, "_resp_v"}, resp_v, 0);
    chk({tag, "_resp_data"}, resp_data, 0);
    chk({tag, "_yumi"}, yumi, 0);
    chk({tag, "_busy"}, busy, 0);
  endtask

  int base0, base1, gb, yb;

  initial begin
    reset_n = 0;
    req_v = '0; resp_credit = '0;
    ic.vaddr_ready = 1; ic.data_v = 0; ic.data = '0;
    rand_credit = 0; ready_en = 1; poison_cnt = 0; miss_ylog = 0; miss_addr = '0;
    for (int i = 0; i < N; i++) begin
      hold[i] = 0; ycnt[i] = 0; gcnt[i] = 0; unc[i] = 0;
      pt[i] = PW'(28'h0ABC000 + i);
    end
    reset_model();

    // 1: requests held through reset, then req0 first and req1 next cycle
    va[0] = 39'h00_0000_1000; va[1] = 39'h00_0000_2000;
    rem[0] = 8; rem[1] = 8; req_v = 2'b11;
    repeat (3) @(negedge clk);
    chk_idle_outputs("rst");
    @(posedge clk); #1;
    reset_n = 1;
    tick(); tick();
    chk("first_grant", 64'(glog[0]), 64'd0);
    chk("second_grant", 64'(glog[1]), 64'd1);

    // 2: two hit streams alternate and retire 16 fetches
    run_idle(200);
    chk("t2_yumi0", 64'(ycnt[0]), 64'd8);
    chk("t2_yumi1", 64'(ycnt[1]), 64'd8);
    for (int k = 0; k < 16; k++) chk("t2_alternate", 64'(glog[k]), 64'(k % 2));

    // 3: req0 misses at 0x8000_0040 while req1 sits in TL
    va[0] = 39'h00_8000_0038; va[1] = 39'h00_0000_3000;
    rem[0] = 3; rem[1] = 3;
    miss_addr = 39'h00_8000_0040; miss_armed = 1;
    base0 = poison_cnt;
    run_idle(200);
    chk("t3_poison", 64'(poison_cnt - base0), 64'd1);
    chk("t3_order0", 64'(ylog[miss_ylog]), 64'd0);
    chk("t3_order1", 64'(ylog[miss_ylog + 1]), 64'd1);

    // 4: withheld credits stall req1 after CRED responses, one pulse frees one more
    rand_credit = 1; hold[1] = 1;
    base0 = ycnt[0]; base1 = ycnt[1]; gb = gcnt[1];
    rem[0] = 8; rem[1] = 8;
    repeat (80) tick();
    chk("t4_req0_streams", 64'(ycnt[0] - base0), 64'd8);
    chk("t4_req1_stall", 64'(ycnt[1] - base1), 64'(CRED));
    pulse[1] = 1;
    repeat (20) tick();
    chk("t4_pulse_resp", 64'(ycnt[1] - base1), 64'(CRED + 1));
    chk("t4_pulse_grant", 64'(gcnt[1] - gb), 64'(CRED + 1));
    hold[1] = 0;
    run_idle(300);
    chk("t4_req1_done", 64'(ycnt[1] - base1), 64'd8);

    // 5: ready low with TL+TV full drains two hits and issues nothing
    rem[0] = 6; rem[1] = 6;
    wait_full(30);
    ready_en = 0;
    gb = gcnt[0] + gcnt[1]; yb = ycnt[0] + ycnt[1];
    repeat (20) tick();
    chk("t5_no_issue", 64'(gcnt[0] + gcnt[1] - gb), 64'd0);
    chk("t5_drain", 64'(ycnt[0] + ycnt[1] - yb), 64'd2);
    ready_en = 1;
    run_idle(300);

    // 6: reset mid-stream clears outputs at once and restores credits
    rem[0] = 6; rem[1] = 6;
    wait_full(30);
    ic.data_v = 1;
    reset_n = 0;
    #1;
    chk_idle_outputs("midrst");
    reset_model();
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset_n = 1;
    hold[1] = 1; rem[0] = 0; rem[1] = 6;
    base1 = ycnt[1];
    repeat (40) tick();
    chk("t6_credits_restored", 64'(ycnt[1] - base1), 64'(CRED));
    hold[1] = 0;
    run_idle(300);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
